alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one ALU instance between NUM_REQ requesters (e.g. 0 = EX stage, 1 = CSR unit).
//  Requesters use a valid/ready request channel and a valid/ready response channel.
//  Arbitration is round-robin. Only one operation is in flight at a time.
//  Sits between the requesters and the ALU: drives alu_op and the operands, and captures the result.
// PARAMETERS
//  NUM_REQ  2   number of requesters (2..8); requester 0 has priority at reset
//  XLEN     32  operand/result width
//  IDW      1   grant index width, = $clog2(NUM_REQ) (min 1)
// PORTS
//  clk          in   1            clock, rising edge
//  reset_n      in   1            asynchronous active-low reset
//  flush        in   1            sync abort of the in-flight op (no response issued)
//  req_valid    in   NUM_REQ      request valid, one bit per requester
//  req_ready    out  NUM_REQ      request accepted (one-hot pulse)
//  req_alu_op   in   4*NUM_REQ    packed alu_op codes, slice i = [4*i+3:4*i]
//  req_src_a    in   XLEN*NUM_REQ packed operand A
//  req_src_b    in   XLEN*NUM_REQ packed operand B
//  rsp_valid    out  NUM_REQ      response valid, one-hot to the owning requester
//  rsp_ready    in   NUM_REQ      response consumed
//  rsp_result   out  XLEN         registered ALU result
//  rsp_zero     out  1            registered ALU zero flag
//  alu_op_o     out  4            to ALU; 4'b1111 when not in EXEC
//  alu_src_a_o  out  XLEN         to ALU; 0 when not in EXEC
//  alu_src_b_o  out  XLEN         to ALU; 0 when not in EXEC
//  alu_result_i in   XLEN         from ALU (combinational)
//  alu_zero_i   in   1            from ALU (combinational)
//  busy         out  1            state != IDLE
//  grant_id     out  IDW          index of current owner; valid while busy
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   state=IDLE, rr_ptr=0, all latches 0, req_ready=0, rsp_valid=0, rsp_result=0,
//   rsp_zero=0, grant_id=0, busy=0, alu_op_o=4'b1111.
//   Reset mid-op discards the op; no response is issued.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE: winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    If a winner exists: req_ready[winner]=1 combinationally in the same cycle
//    (accept = valid&ready); latch op/a/b and grant_id=winner; next state EXEC.
//    If no req_valid bit is set: stay in IDLE.
//   EXEC (exactly 1 cycle): drive the ALU from the latches; capture alu_result_i/alu_zero_i
//    into rsp_result/rsp_zero at the clock edge; next state RESP.
//   RESP: rsp_valid[grant_id]=1 and rsp_result/rsp_zero held stable.
//    On rsp_ready[grant_id]=1: rr_ptr=(grant_id+1) mod NUM_REQ; next state IDLE.
//    rsp_ready of non-owners is ignored. Otherwise stay in RESP (back-pressure, no timeout).
//  Timing:
//   Request-accept to rsp_valid = 2 cycles; max throughput 1 op per 3 cycles.
//   No new request is accepted unless in IDLE, so req_ready=0 in EXEC/RESP.
//  flush=1 in EXEC or RESP: next state IDLE, rsp_valid drops next cycle, rr_ptr advances past grant_id.
//   flush in IDLE has priority over acceptance: req_ready=0 that cycle.
//  Simultaneous rsp_ready and new req_valid in RESP: the response completes;
//   the new request is arbitrated the next cycle (in IDLE).
//  rr_ptr wraps from NUM_REQ-1 to 0.
//  alu_op codes pass through unchanged: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor,
//   0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 clear, 1111 pass.
//  Unused packed slices are ignored.
// TESTING
//  T1 reset: reset_n=0 mid-EXEC -> next sample busy=0, rsp_valid=0, alu_op_o=1111; no rsp after release.
//  T2 single op: req0 op=0001 a=5 b=5 -> req_ready[0] in cycle 0, rsp_valid[0] at cycle 2, result=0, zero=1.
//  T3 fairness: req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1;
//     req1 op=0101 a=-1 b=1 -> result=1.
//  T4 back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and result stable; req_ready stays 0.
//  T5 flush: flush=1 in EXEC -> no rsp_valid; next grant goes to the other requester; busy=0 after 1 cycle.
//  T6 wrap: NUM_REQ=3, only req2 then req0 valid -> rr_ptr 0->0 (after 2), grant 0 follows; sra 0x80000000>>4 = 0xF8000000.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// One op in flight: IDLE -> EXEC -> RESP, with flush and back-pressure.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_alu_op,
  input  logic [XLEN*NUM_REQ-1:0] req_src_a,
  input  logic [XLEN*NUM_REQ-1:0] req_src_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_result,
  output logic                    rsp_zero,
  output logic [3:0]              alu_op_o,
  output logic [XLEN-1:0]         alu_src_a_o,
  output logic [XLEN-1:0]         alu_src_b_o,
  input  logic [XLEN-1:0]         alu_result_i,
  input  logic                    alu_zero_i,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_gid;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic            w_accept;
  logic            w_release;
  logic [IDW-1:0]  w_ptr_nxt;

  // Round-robin scan starting at r_rr_ptr; lowest offset wins.
  always_comb begin
    int w_idx;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(w_idx);
      end
    end
  end

  assign w_ptr_nxt = (r_gid == IDW'(NUM_REQ - 1)) ? '0
                   : r_gid + IDW'(1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshakes and ALU drive.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    alu_op_o    = 4'b1111;
    alu_src_a_o = '0;
    alu_src_b_o = '0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!flush && w_found) begin
          req_ready[w_win] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op_o    = r_op;
        alu_src_a_o = r_a;
        alu_src_b_o = r_b;
        if (flush) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[r_gid] = 1'b1;
        if (flush || rsp_ready[r_gid]) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latches, result capture and fairness pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_gid    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gid <= w_win;
        r_op  <= req_alu_op[int'(w_win)*4 +: 4];
        r_a   <= req_src_a[int'(w_win)*XLEN +: XLEN];
        r_b   <= req_src_b[int'(w_win)*XLEN +: XLEN];
      end
      if (r_state == S_EXEC && !flush) begin
        r_result <= alu_result_i;
        r_zero   <= alu_zero_i;
      end
      if (w_release) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign grant_id   = r_gid;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction model,
// per-cycle compare, directed cases and random traffic.
module tb_alu_share_arbiter;

  localparam int NR  = 3;
  localparam int XL  = 32;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [4*NR-1:0]   req_alu_op;
  logic [XL*NR-1:0]  req_src_a;
  logic [XL*NR-1:0]  req_src_b;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [XL-1:0]     rsp_result;
  logic              rsp_zero;
  logic [3:0]        alu_op_o;
  logic [XL-1:0]     alu_src_a_o;
  logic [XL-1:0]     alu_src_b_o;
  logic [XL-1:0]     alu_result_i;
  logic              alu_zero_i;
  logic              busy;
  logic [IDW-1:0]    grant_id;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(NR), .XLEN(XL), .IDW(IDW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_alu_op(req_alu_op), .req_src_a(req_src_a),
    .req_src_b(req_src_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .alu_op_o(alu_op_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [32:0] alu_f(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = {31'b0, $signed(a) < $signed(b)};
      4'h6: r = {31'b0, a < b};
      4'h7: r = a << b[4:0];
      4'h8: r = a >> b[4:0];
      4'h9: r = $unsigned($signed(a) >>> b[4:0]);
      4'hF: r = a;
      default: r = 32'h0;
    endcase
    return {(r == 32'h0), r};
  endfunction

  assign {alu_zero_i, alu_result_i} =
    alu_f(alu_op_o, alu_src_a_o, alu_src_b_o);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 executing, 2 responding.
  int          m_phase, m_owner, m_ptr;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  logic        m_zero;

  function automatic int winner(input int p, input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_owner = 0; m_ptr = 0;
      m_op = 0; m_a = 0; m_b = 0; m_res = 0; m_zero = 0;
    end else begin
      int w;
      w = winner(m_ptr, req_valid);
      if (m_phase == 0) begin
        if (!flush && w >= 0) begin
          m_owner = w;
          m_op    = req_alu_op[4*w +: 4];
          m_a     = req_src_a[XL*w +: XL];
          m_b     = req_src_b[XL*w +: XL];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (flush) begin
          m_phase = 0;
          m_ptr   = (m_owner + 1) % NR;
        end else begin
          {m_zero, m_res} = alu_f(m_op, m_a, m_b);
          m_phase = 2;
        end
      end else begin
        if (flush || rsp_ready[m_owner]) begin
          m_phase = 0;
          m_ptr   = (m_owner + 1) % NR;
        end
      end
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int w;
      logic [NR-1:0] e_rdy, e_rv;
      w = winner(m_ptr, req_valid);
      e_rdy = '0;
      e_rv  = '0;
      if (m_phase == 0 && !flush && w >= 0) e_rdy[w] = 1'b1;
      if (m_phase == 2) e_rv[m_owner] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("grant_id", 64'(grant_id), 64'(m_owner));
      chk("rsp_result", 64'(rsp_result), 64'(m_res));
      chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
      chk("alu_op_o", 64'(alu_op_o),
          64'((m_phase == 1) ? m_op : 4'hF));
      chk("alu_src_a_o", 64'(alu_src_a_o),
          64'((m_phase == 1) ? m_a : 32'h0));
      chk("alu_src_b_o", 64'(alu_src_b_o),
          64'((m_phase == 1) ? m_b : 32'h0));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_alu_op[4*i +: 4] = op;
    req_src_a[XL*i +: XL] = a;
    req_src_b[XL*i +: XL] = b;
  endtask

  int grants[$];
  logic [3:0] ops[12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                          4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};

  initial begin
    reset_n = 1'b0; flush = 1'b0;
    req_valid = '0; rsp_ready = '0;
    req_alu_op = '0; req_src_a = '0; req_src_b = '0;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_alu_op", 64'(alu_op_o), 64'hF);
    chk("rst_grant", 64'(grant_id), 64'h0);
    chk("rst_result", 64'(rsp_result), 64'h0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    step();

    // Single op: sub 5-5.
    set_req(0, 4'h1, 32'd5, 32'd5);
    req_valid = 3'b001; rsp_ready = 3'b001;
    #1 chk("t2_ready_c0", 64'(req_ready), 64'h1);
    step(); req_valid = '0;
    step();
    chk("t2_rsp_c2", 64'(rsp_valid), 64'h1);
    chk("t2_result", 64'(rsp_result), 64'h0);
    chk("t2_zero", 64'(rsp_zero), 64'h1);
    step(); step();

    // Reset in the middle of EXEC.
    set_req(0, 4'h0, 32'd9, 32'd9);
    req_valid = 3'b001;
    step();
    chk("t1_in_exec", 64'(busy), 64'h1);
    reset_n = 1'b0; req_valid = '0;
    #1;
    chk("t1_busy", 64'(busy), 64'h0);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("t1_alu_op", 64'(alu_op_o), 64'hF);
    step(); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_no_rsp", 64'(rsp_valid), 64'h0);
    end

    // Fairness between requesters 0 and 1.
    set_req(0, 4'h0, 32'd1, 32'd2);
    set_req(1, 4'h5, 32'hFFFF_FFFF, 32'd1);
    req_valid = 3'b011; rsp_ready = 3'b111;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req_ready == 3'b001) grants.push_back(0);
      if (req_ready == 3'b010) grants.push_back(1);
      if (req_ready == 3'b100) grants.push_back(2);
      if (rsp_valid == 3'b010)
        chk("t3_slt", 64'(rsp_result), 64'h1);
      if (i == 11) req_valid = '0;
      step();
    end
    chk("t3_ngrants", 64'(grants.size()), 64'd4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk("t3_grant", 64'(grants[i]), 64'(i % 2));

    // Back-pressure: response held for 5 cycles.
    set_req(0, 4'h0, 32'd3, 32'd4);
    rsp_ready = '0; req_valid = 3'b001;
    step(); req_valid = 3'b010;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("t4_result", 64'(rsp_result), 64'd7);
      chk("t4_req_ready", 64'(req_ready), 64'h0);
      step();
    end
    rsp_ready = 3'b001; req_valid = '0;
    step();
    rsp_ready = '0;

    // Flush during EXEC of requester 1.
    set_req(1, 4'h2, 32'hF0, 32'h3C);
    req_valid = 3'b010;
    #1 chk("t5_grant1", 64'(req_ready), 64'h2);
    step(); req_valid = '0; flush = 1'b1;
    step(); flush = 1'b0;
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_no_rsp", 64'(rsp_valid), 64'h0);
    req_valid = 3'b011; flush = 1'b1;
    #1 chk("t5_flush_idle", 64'(req_ready), 64'h0);
    flush = 1'b0;
    #1 chk("t5_other", 64'(req_ready), 64'h1);
    rsp_ready = 3'b111;
    step(); req_valid = '0;
    step(); step();

    // Wrap with three requesters.
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    set_req(2, 4'h9, 32'h8000_0000, 32'd4);
    req_valid = 3'b100;
    #1 chk("t6_grant2", 64'(req_ready), 64'h4);
    step(); req_valid = '0;
    step();
    chk("t6_rsp2", 64'(rsp_valid), 64'h4);
    chk("t6_sra", 64'(rsp_result), 64'hF800_0000);
    step();
    req_valid = 3'b101;
    #1 chk("t6_wrap0", 64'(req_ready), 64'h1);
    step(); req_valid = '0;
    step(); step();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      req_valid = NR'($urandom_range(0, 7));
      rsp_ready = NR'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NR; i++)
        set_req(i, ops[$urandom_range(0, 11)],
                ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
                ($urandom_range(0, 3) == 0) ? 32'(i) : $urandom);
      if (c == 300) reset_n = 1'b0;
      if (c == 302) reset_n = 1'b1;
      step();
    end
    req_valid = '0; rsp_ready = '1; flush = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
